// File: rtl/psum_rx_pkg.sv
// psum_rx_pkg: shared sizes and FSM encoding for the Psum spike receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psum_rx_pkg;

  localparam int TIME_STEPS    = 4;
  localparam int LANE_W        = 20;
  localparam int ELEM_PER_WORD = 16;
  localparam int PSUM_W        = TIME_STEPS * LANE_W;          // 80-bit Psum element
  localparam int DATA_W        = ELEM_PER_WORD * TIME_STEPS;   // 64-bit spike-RAM word
  localparam int CNT_W         = $clog2(ELEM_PER_WORD) + 1;    // counts 0..16

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lif_neuron_4t.sv
// lif_neuron_4t: leaky integrate-and-fire over 4 time steps for one Psum element.
// Latency: purely combinational.
// Backpressure: none.
module lif_neuron_4t
  import psum_rx_pkg::*;
#(
  parameter logic signed [LANE_W-1:0] P_VTH = 20'sd256
) (
  input  logic [PSUM_W-1:0]     lanes,
  output logic [TIME_STEPS-1:0] spk
);

  // Threshold widened to the 21-bit membrane arithmetic.
  localparam logic signed [LANE_W:0] VTH_X = {P_VTH[LANE_W-1], P_VTH};

  logic signed [LANE_W:0] v;
  logic signed [LANE_W:0] sum;
  logic signed [LANE_W:0] h;

  // Walk the time steps in order; potential resets to zero on a spike.
  always_comb begin
    v   = '0;
    sum = '0;
    h   = '0;
    spk = '0;
    for (int t = 0; t < TIME_STEPS; t++) begin
      sum    = v + $signed({lanes[LANE_W*t + LANE_W - 1], lanes[LANE_W*t +: LANE_W]});
      h      = sum >>> 1;
      spk[t] = (h >= VTH_X);
      v      = spk[t] ? '0 : h;
    end
  end

endmodule

// File: rtl/psum_spike_receiver.sv
// psum_spike_receiver: turns Psum elements into LIF spike nibbles and packs 16 per spike-RAM word.
// Latency: o_wr_en 2 cycles after the edge sampling the 16th element; partial word flushed after Finish.
// Backpressure: none; valids in IDLE/RUN always accepted, valids after Finish dropped and flagged.
// Optional: define SPIKE_CNT_EN to add the saturating o_spike_cnt output.
module psum_spike_receiver
  import psum_rx_pkg::*;
#(
  parameter logic signed [LANE_W-1:0] P_VTH    = 20'sd256,
  parameter int                       P_ADDR_W = 12
) (
  input  logic                s_clk,
  input  logic                s_rst_n,
  input  logic                i_PsumValid,
  input  logic [PSUM_W-1:0]   i_PsumData,
  input  logic                i_Psum_Finish,
  output logic                o_wr_en,
  output logic [P_ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic                o_done,
  output logic                o_err_late
`ifdef SPIKE_CNT_EN
  ,
  output logic [15:0]         o_spike_cnt
`endif
);

  state_t                state;
  state_t                state_nxt;
  logic                  fin_q;
  logic                  fin_rise;
  logic                  accept;
  logic                  late;
  logic                  s1_vld;
  logic [PSUM_W-1:0]     s1_dat;
  logic [TIME_STEPS-1:0] spk;
  logic [CNT_W-1:0]      pack_cnt;
  logic [CNT_W-1:0]      slot;
  logic [DATA_W-1:0]     pack;
  logic                  word_full;
  logic                  flush_wr;
  logic                  wr_fire;

  // fin_q is held low while idle, so a Finish that was already high when the
  // first element arrives still looks like a rising edge once in RUN.
  assign fin_rise  = i_Psum_Finish & ~fin_q;
  assign accept    = i_PsumValid & ((state == S_IDLE) | (state == S_RUN));
  assign late      = i_PsumValid & ((state == S_FLUSH) | (state == S_DONE));
  // pack_cnt == 16 lasts one cycle: the completed word is written out next edge.
  assign word_full = (pack_cnt == CNT_W'(ELEM_PER_WORD));
  assign flush_wr  = (state == S_FLUSH) & ~s1_vld & (pack_cnt != '0) & ~word_full;
  assign wr_fire   = word_full | flush_wr;
  assign slot      = word_full ? '0 : pack_cnt;
  assign o_done    = (state == S_DONE);

  lif_neuron_4t #(
    .P_VTH (P_VTH)
  ) u_lif (
    .lanes (s1_dat),
    .spk   (spk)
  );

  // State register.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: leave RUN on Finish, finish FLUSH once nothing is left to write.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (i_PsumValid)                        state_nxt = S_RUN;
      S_RUN:   if (fin_rise)                           state_nxt = S_FLUSH;
      S_FLUSH: if (!s1_vld && (pack_cnt == '0))        state_nxt = S_DONE;
      S_DONE:                                          state_nxt = S_DONE;
      default:                                         state_nxt = S_IDLE;
    endcase
  end

  // Finish edge detector, disarmed while idle.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) fin_q <= 1'b0;
    else          fin_q <= (state == S_IDLE) ? 1'b0 : i_Psum_Finish;
  end

  // Stage 1: capture accepted elements.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_dat <= i_PsumData;
    end
  end

  // Stage 2: drop the spike nibble into its slot; a word being written frees the register.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      pack     <= '0;
      pack_cnt <= '0;
    end else begin
      if (wr_fire) begin
        pack     <= '0;
        pack_cnt <= '0;
      end
      if (s1_vld) begin
        pack[slot*TIME_STEPS +: TIME_STEPS] <= spk;
        pack_cnt                            <= slot + CNT_W'(1);
      end
    end
  end

  // Write port: one-cycle strobe, address advances after every write.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      o_wr_en   <= 1'b0;
      o_wr_data <= '0;
      o_wr_addr <= '0;
    end else begin
      o_wr_en <= wr_fire;
      if (wr_fire) o_wr_data <= pack;
      if (o_wr_en) o_wr_addr <= o_wr_addr + P_ADDR_W'(1);
    end
  end

  // Sticky flag for elements arriving after Finish.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) o_err_late <= 1'b0;
    else if (late) o_err_late <= 1'b1;
  end

`ifdef SPIKE_CNT_EN
  logic [16:0] cnt_sum;

  // Running spike total plus this element's spikes, one bit of headroom for saturation.
  always_comb begin
    cnt_sum = {1'b0, o_spike_cnt} + 17'($countones(spk));
  end

  // Saturating spike counter.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) o_spike_cnt <= '0;
    else if (s1_vld) o_spike_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_psum_spike_receiver.sv
// tb_psum_spike_receiver: randomized self-checking bench with a floor-division LIF reference model.
// Latency: checks write strobe timing, flush and done timing against sampled-edge cycle numbers.
// Backpressure: n/a (DUT has no ready).
module tb_psum_spike_receiver;

  localparam int ADDR_W = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [79:0] dat;
  logic        fin;
  logic        wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0] wr_data;
  logic        done;
  logic        err_late;
`ifdef SPIKE_CNT_EN
  logic [15:0] spike_cnt;
`endif

  psum_spike_receiver #(
    .P_VTH    (20'sd256),
    .P_ADDR_W (ADDR_W)
  ) dut (
    .s_clk         (clk),
    .s_rst_n       (rst_n),
    .i_PsumValid   (vld),
    .i_PsumData    (dat),
    .i_Psum_Finish (fin),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_done        (done),
    .o_err_late    (err_late)
`ifdef SPIKE_CNT_EN
    ,
    .o_spike_cnt   (spike_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  wr_t         wr_q[$];
  logic [79:0] elem_q[$];
  int          samp_q[$];
  int          done_cyc = -1;
  int          n_chk = 0;
  int          n_fail = 0;
  wr_t         mon_w;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      mon_w.addr = int'(wr_addr);
      mon_w.data = wr_data;
      mon_w.cyc  = cyc;
      wr_q.push_back(mon_w);
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  // Reference: v integrates, h = floor((v+x)/2), spike when h >= 256.
  function automatic logic [3:0] ref_nib(input logic [79:0] d);
    int               v, s, h;
    logic signed [19:0] lane;
    logic [3:0]       r;
    v = 0;
    r = '0;
    for (int t = 0; t < 4; t++) begin
      lane = d[20*t +: 20];
      s    = v + lane;
      h    = (s >= 0) ? s / 2 : -((1 - s) / 2);
      r[t] = (h >= 256);
      v    = r[t] ? 0 : h;
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_word(input int start, input int n);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[4*k +: 4] = ref_nib(elem_q[start + k]);
    return w;
  endfunction

  function automatic logic [79:0] rand_elem();
    logic [79:0] d;
    int          r;
    for (int t = 0; t < 4; t++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      d[20*t +: 20] = 20'h7FFFF;
      else if (r == 1) d[20*t +: 20] = 20'h80000;
      else             d[20*t +: 20] = 20'($urandom_range(0, 1400) - 500);
    end
    return d;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    vld   = 1'b0;
    fin   = 1'b0;
    dat   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wr_q.delete();
    elem_q.delete();
    samp_q.delete();
    done_cyc = -1;
  endtask

  task automatic send(input logic [79:0] d);
    @(posedge clk);
    #1;
    vld = 1'b1;
    dat = d;
    elem_q.push_back(d);
    samp_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 vld = 1'b0;
    end
  endtask

  task automatic wait_writes(input int n);
    for (int k = 0; k < 80 && wr_q.size() < n; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 80 && done !== 1'b1; k++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    n_chk++; if (wr_addr !== '0)    begin n_fail++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
    n_chk++; if (wr_data !== '0)    begin n_fail++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
    n_chk++; if (done !== 1'b0)     begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_chk++; if (err_late !== 1'b0) begin n_fail++; $display("FAIL rst_err_late: got %b want 0", err_late); end
  endtask

  // Four constant-lane words streamed back to back.
  task automatic test_lif_patterns();
    logic [19:0] pat_lane[4];
    logic [3:0]  pat_nib[4];
    logic [63:0] exp_w;
    pat_lane = '{20'd512, 20'd300, 20'hFFC18, 20'h7FFFF};
    pat_nib  = '{4'hF, 4'b0100, 4'h0, 4'hF};
    do_reset();
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 16; k++) send({4{pat_lane[p]}});
    idle(1);
    wait_writes(4);
    n_chk++; if (wr_q.size() !== 4) begin n_fail++; $display("FAIL pat_wr_count: got %0d want 4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      exp_w = {16{pat_nib[i]}};
      n_chk++; if (wr_q[i].data !== exp_w) begin n_fail++; $display("FAIL pat_data[%0d]: got %h want %h", i, wr_q[i].data, exp_w); end
      n_chk++; if (wr_q[i].addr !== i) begin n_fail++; $display("FAIL pat_addr[%0d]: got %0d want %0d", i, wr_q[i].addr, i); end
      n_chk++; if (wr_q[i].cyc - samp_q[16*i + 15] !== 2) begin n_fail++; $display("FAIL pat_latency[%0d]: got %0d want 2", i, wr_q[i].cyc - samp_q[16*i + 15]); end
    end
  endtask

  // 40 random elements with gaps, then Finish: two full words and one 8-element partial.
  task automatic test_flush_partial();
    logic [63:0] exp_w;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      send(rand_elem());
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);
    fin = 1'b1;
    wait_done();
    n_chk++; if (wr_q.size() !== 3) begin n_fail++; $display("FAIL flush_wr_count: got %0d want 3", wr_q.size()); end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      exp_w = ref_word(16*i, (i == 2) ? 8 : 16);
      n_chk++; if (wr_q[i].data !== exp_w) begin n_fail++; $display("FAIL flush_data[%0d]: got %h want %h", i, wr_q[i].data, exp_w); end
      n_chk++; if (wr_q[i].addr !== i) begin n_fail++; $display("FAIL flush_addr[%0d]: got %0d want %0d", i, wr_q[i].addr, i); end
    end
    if (wr_q.size() >= 3) begin
      n_chk++; if (wr_q[2].data[63:32] !== 32'h0) begin n_fail++; $display("FAIL flush_upper_zero: got %h want 0", wr_q[2].data[63:32]); end
      n_chk++; if (done_cyc !== wr_q[2].cyc + 1) begin n_fail++; $display("FAIL flush_done_timing: got cycle %0d want %0d", done_cyc, wr_q[2].cyc + 1); end
    end
    n_chk++; if (err_late !== 1'b0) begin n_fail++; $display("FAIL flush_err_late: got %b want 0", err_late); end
  endtask

  // 17th element arrives on the same cycle as the Finish rising edge.
  task automatic test_finish_coincident();
    logic [63:0] exp_w;
    do_reset();
    for (int k = 0; k < 16; k++) send(rand_elem());
    send(rand_elem());
    fin = 1'b1;
    idle(1);
    wait_done();
    n_chk++; if (wr_q.size() !== 2) begin n_fail++; $display("FAIL coinc_wr_count: got %0d want 2", wr_q.size()); end
    for (int i = 0; i < 2 && i < wr_q.size(); i++) begin
      exp_w = ref_word(16*i, (i == 1) ? 1 : 16);
      n_chk++; if (wr_q[i].data !== exp_w || wr_q[i].addr !== i) begin
        n_fail++; $display("FAIL coinc_write[%0d]: got addr %0d data %h want addr %0d data %h", i, wr_q[i].addr, wr_q[i].data, i, exp_w);
      end
    end
    if (wr_q.size() >= 2) begin
      n_chk++; if (done_cyc !== wr_q[1].cyc + 1) begin n_fail++; $display("FAIL coinc_done_timing: got cycle %0d want %0d", done_cyc, wr_q[1].cyc + 1); end
    end
  endtask

  // Finish already high before the only element; then a late element after done.
  task automatic test_idle_finish_and_late();
    logic [63:0] exp_w;
    do_reset();
    @(posedge clk);
    #1 fin = 1'b1;
    idle(2);
    send(rand_elem());
    idle(1);
    wait_done();
    exp_w = ref_word(0, 1);
    n_chk++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL idlefin_wr_count: got %0d want 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      n_chk++; if (wr_q[0].data !== exp_w || wr_q[0].addr !== 0) begin
        n_fail++; $display("FAIL idlefin_write: got addr %0d data %h want addr 0 data %h", wr_q[0].addr, wr_q[0].data, exp_w);
      end
    end
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL idlefin_done: got %b want 1", done); end
    send(rand_elem());
    idle(4);
    @(negedge clk);
    n_chk++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL late_no_write: got %0d writes want 1", wr_q.size()); end
    n_chk++; if (err_late !== 1'b1) begin n_fail++; $display("FAIL late_err: got %b want 1", err_late); end
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL late_done_hold: got %b want 1", done); end
  endtask

  // Reset in the middle of the second word; the next full word must land at address 0.
  task automatic test_reset_midword();
    logic [63:0] exp_w;
    do_reset();
    for (int k = 0; k < 23; k++) send(rand_elem());
    @(posedge clk);
    #3 rst_n = 1'b0;
    vld = 1'b0;
    #1;
    n_chk++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL midrst_wr_en: got %b want 0", wr_en); end
    n_chk++; if (wr_addr !== '0)    begin n_fail++; $display("FAIL midrst_wr_addr: got %0d want 0", wr_addr); end
    n_chk++; if (wr_data !== '0)    begin n_fail++; $display("FAIL midrst_wr_data: got %h want 0", wr_data); end
    n_chk++; if (done !== 1'b0)     begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
    n_chk++; if (err_late !== 1'b0) begin n_fail++; $display("FAIL midrst_err_late: got %b want 0", err_late); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr_q.delete();
    elem_q.delete();
    samp_q.delete();
    for (int k = 0; k < 16; k++) send(rand_elem());
    idle(1);
    wait_writes(1);
    exp_w = ref_word(0, 16);
    n_chk++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL midrst_wr_count: got %0d want 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      n_chk++; if (wr_q[0].addr !== 0) begin n_fail++; $display("FAIL midrst_addr: got %0d want 0", wr_q[0].addr); end
      n_chk++; if (wr_q[0].data !== exp_w) begin n_fail++; $display("FAIL midrst_data: got %h want %h", wr_q[0].data, exp_w); end
    end
  endtask

  // Nine random words through a 3-bit address: last one wraps to 0.
  task automatic test_addr_wrap();
    logic [63:0] exp_w;
    do_reset();
    for (int k = 0; k < 144; k++) begin
      send(rand_elem());
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(1);
    wait_writes(9);
    n_chk++; if (wr_q.size() !== 9) begin n_fail++; $display("FAIL wrap_wr_count: got %0d want 9", wr_q.size()); end
    for (int i = 0; i < 9 && i < wr_q.size(); i++) begin
      exp_w = ref_word(16*i, 16);
      n_chk++; if (wr_q[i].addr !== (i % 8)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, wr_q[i].addr, i % 8); end
      n_chk++; if (wr_q[i].data !== exp_w) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, wr_q[i].data, exp_w); end
    end
  endtask

`ifdef SPIKE_CNT_EN
  task automatic test_spike_cnt();
    do_reset();
    for (int k = 0; k < 16; k++) send({4{20'd512}});
    idle(4);
    @(negedge clk);
    n_chk++; if (spike_cnt !== 16'd64) begin n_fail++; $display("FAIL spike_cnt: got %0d want 64", spike_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    vld   = 1'b0;
    fin   = 1'b0;
    dat   = '0;
    test_reset();
    test_lif_patterns();
    test_flush_partial();
    test_finish_coincident();
    test_idle_finish_and_late();
    test_reset_midword();
    test_addr_wrap();
`ifdef SPIKE_CNT_EN
    test_spike_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
